// File: rtl/dram_wbl_write_ctrl_pkg.sv
// dram_wbl_write_ctrl_pkg: shared DRAM write-path states, lane count and default timings
package dram_wbl_write_ctrl_pkg;
  localparam int NUM_LANES   = 16;
  localparam int DEF_T_SETUP = 2;
  localparam int DEF_T_WE    = 4;
  localparam int DEF_T_REC   = 2;
  typedef enum logic [2:0] {IDLE, SETUP, WRITE, GAP, REC, DONE} wr_state_e;
  typedef logic [63:0] word_t;
endpackage

// File: rtl/dram_wbl_write_ctrl_if.sv
// dram_wbl_write_ctrl_if: row-write request and word-line/bit-line drive bundle
interface dram_wbl_write_ctrl_if
  import dram_wbl_write_ctrl_pkg::*;
  ;
  logic       io_en;
  logic [5:0] addr;
  word_t      wbl_data [NUM_LANES];
  logic       wr_done;
  logic       busy;
  logic       err_ovf;
  logic       wl_en;
  logic [5:0] wl_addr;
  logic       we;
  logic [3:0] lane;
  word_t      wbl;
  modport master (
    output io_en, addr, wbl_data,
    input  wr_done, busy, err_ovf, wl_en, wl_addr, we, lane, wbl
  );
  modport slave (
    input  io_en, addr, wbl_data,
    output wr_done, busy, err_ovf, wl_en, wl_addr, we, lane, wbl
  );
endinterface

// File: rtl/dram_wbl_write_ctrl_wbl_lane_mux.sv
// wbl_lane_mux: picks the active lane word out of the latched row
module wbl_lane_mux
  import dram_wbl_write_ctrl_pkg::*;
(
  input  word_t      words_i [NUM_LANES],
  input  logic [3:0] sel_i,
  output word_t      word_o
);
  assign word_o = words_i[sel_i];
endmodule

// File: rtl/dram_wbl_write_ctrl.sv
// dram_wbl_write_ctrl: sequences one 16-lane row write: setup, per-lane WE pulses with gaps, recovery
module dram_wbl_write_ctrl
  import dram_wbl_write_ctrl_pkg::*;
#(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_WE    = DEF_T_WE,
  parameter int T_REC   = DEF_T_REC
) (
  input logic                  clk,
  input logic                  rst,
  dram_wbl_write_ctrl_if.slave bus
);
  wr_state_e  state_q;
  logic [3:0] cnt_q, lane_q;
  logic [5:0] addr_q;
  word_t      data_q [NUM_LANES];
  word_t      word;
  logic       wl_en_q, we_q, done_q, busy_q, err_q, cnt_zero, last_lane;
  assign cnt_zero  = cnt_q == 4'd0;
  assign last_lane = lane_q == 4'(NUM_LANES - 1);
  wbl_lane_mux u_mux (.words_i(data_q), .sel_i(lane_q), .word_o(word));
  // counters load N-1 on state entry so each state lasts exactly N cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lane_q  <= '0;
      addr_q  <= '0;
      wl_en_q <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) data_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.io_en && state_q != IDLE) err_q <= 1'b1;
      case (state_q)
        IDLE: if (bus.io_en) begin
          state_q <= SETUP;
          cnt_q   <= 4'(T_SETUP - 1);
          lane_q  <= '0;
          addr_q  <= bus.addr;
          data_q  <= bus.wbl_data;
          wl_en_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        SETUP: if (cnt_zero) begin
          state_q <= WRITE;
          cnt_q   <= 4'(T_WE - 1);
          we_q    <= 1'b1;
        end else cnt_q <= cnt_q - 4'd1;
        WRITE: if (cnt_zero) begin
          we_q    <= 1'b0;
          state_q <= last_lane ? REC : GAP;
          cnt_q   <= 4'(T_REC - 1);
        end else cnt_q <= cnt_q - 4'd1;
        GAP: begin
          state_q <= WRITE;
          cnt_q   <= 4'(T_WE - 1);
          lane_q  <= lane_q + 4'd1;
          we_q    <= 1'b1;
        end
        REC: if (cnt_zero) begin
          state_q <= DONE;
          wl_en_q <= 1'b0;
          lane_q  <= '0;
          done_q  <= 1'b1;
        end else cnt_q <= cnt_q - 4'd1;
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.wr_done = done_q;
  assign bus.busy    = busy_q;
  assign bus.err_ovf = err_q;
  assign bus.wl_en   = wl_en_q;
  assign bus.wl_addr = addr_q;
  assign bus.we      = we_q;
  assign bus.lane    = lane_q;
  assign bus.wbl     = wl_en_q ? word : '0;
endmodule

// File: tb/tb_dram_wbl_write_ctrl.sv
// tb_dram_wbl_write_ctrl: directed row-write vectors against default and minimum-timing instances
module tb_dram_wbl_write_ctrl;
  import dram_wbl_write_ctrl_pkg::*;
  typedef struct {
    int         n;
    logic       wl_en;
    logic       we;
    logic       done;
    logic       busy;
    logic [3:0] lane;
  } tl_t;
  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  sel = 1'b0;
  int    total = 0;
  int    passed = 0;
  word_t exp_w [NUM_LANES];
  tl_t   tl [13];
  dram_wbl_write_ctrl_if b0 ();
  dram_wbl_write_ctrl_if b1 ();
  dram_wbl_write_ctrl dut0 (.clk(clk), .rst(rst), .bus(b0));
  dram_wbl_write_ctrl #(.T_SETUP(1), .T_WE(1), .T_REC(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  always #5 clk = ~clk;
  logic       ob_done, ob_busy, ob_err, ob_wl_en, ob_we;
  logic [5:0] ob_wl_addr;
  logic [3:0] ob_lane;
  word_t      ob_wbl;
  assign ob_done    = sel ? b1.wr_done : b0.wr_done;
  assign ob_busy    = sel ? b1.busy    : b0.busy;
  assign ob_err     = sel ? b1.err_ovf : b0.err_ovf;
  assign ob_wl_en   = sel ? b1.wl_en   : b0.wl_en;
  assign ob_we      = sel ? b1.we      : b0.we;
  assign ob_wl_addr = sel ? b1.wl_addr : b0.wl_addr;
  assign ob_lane    = sel ? b1.lane    : b0.lane;
  assign ob_wbl     = sel ? b1.wbl     : b0.wbl;

  function automatic word_t pat(input int k, input logic [63:0] key);
    return (64'h0101010101010101 * 64'(k + 1)) ^ key;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, req);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [5:0] a, input logic [63:0] key);
    b0.io_en = en & ~sel;
    b1.io_en = en & sel;
    b0.addr  = a;
    b1.addr  = a;
    for (int k = 0; k < NUM_LANES; k++) begin
      b0.wbl_data[k] = pat(k, key);
      b1.wbl_data[k] = pat(k, key);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " wr_done"}, 64'(ob_done), 64'd0);
    chk({tag, " busy"}, 64'(ob_busy), 64'd0);
    chk({tag, " err_ovf"}, 64'(ob_err), 64'd0);
    chk({tag, " wl_en"}, 64'(ob_wl_en), 64'd0);
    chk({tag, " wl_addr"}, 64'(ob_wl_addr), 64'd0);
    chk({tag, " we"}, 64'(ob_we), 64'd0);
    chk({tag, " lane"}, 64'(ob_lane), 64'd0);
    chk({tag, " wbl"}, ob_wbl, 64'd0);
  endtask

  // One row write; inj = cycle index during which a stray IO_EN is driven, rst_at = cycle of reset
  task automatic run(input logic [5:0] a, input logic [63:0] key, input int twe, input int lat,
                     input int inj, input int rst_at, input bit use_tl, input bit exp_err);
    int pulses = 0, hi = 0, lo = 0, dones = 0, seen = -1, nl = 0;
    int e_w = 0, e_g = 0, e_l = 0, e_d = 0;
    bit prev = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) exp_w[k] = pat(k, key);
    drive(1'b1, a, key);
    tick;
    drive(1'b0, ~a, ~key);
    for (int n = 0; n < lat + 4; n++) begin
      if (n == 0) chk("wl_addr latched", 64'(ob_wl_addr), 64'(a));
      if (use_tl) foreach (tl[i]) if (tl[i].n == n) begin
        chk($sformatf("t%0d wl_en", n), 64'(ob_wl_en), 64'(tl[i].wl_en));
        chk($sformatf("t%0d we", n), 64'(ob_we), 64'(tl[i].we));
        chk($sformatf("t%0d wr_done", n), 64'(ob_done), 64'(tl[i].done));
        chk($sformatf("t%0d busy", n), 64'(ob_busy), 64'(tl[i].busy));
        if (tl[i].wl_en || !tl[i].busy) chk($sformatf("t%0d lane", n), 64'(ob_lane), 64'(tl[i].lane));
        if (tl[i].we) chk($sformatf("t%0d wbl", n), ob_wbl, exp_w[tl[i].lane]);
      end
      if (ob_we) begin
        if (!prev) begin
          if (ob_lane != 4'(nl)) e_l++;
          if (pulses > 0 && lo != 1) e_g++;
          nl++;
          pulses++;
          hi = 0;
        end
        hi++;
        if (ob_wbl !== exp_w[ob_lane]) e_d++;
      end else begin
        if (prev && hi != twe) e_w++;
        if (prev) lo = 0;
        lo++;
      end
      prev = ob_we;
      if (ob_done) begin
        dones++;
        if (seen < 0) seen = n + 1;
      end
      if (n == inj) drive(1'b1, ~a, ~key);
      if (n == rst_at) begin
        rst = 1'b1;
        drive(1'b1, ~a, ~key);
      end
      tick;
      drive(1'b0, ~a, ~key);
      if (n == rst_at) begin
        rst = 1'b0;
        chk_zero("abort");
      end
      if (seen >= 0) break;
    end
    if (rst_at < 0) begin
      chk("wr_done count", 64'(dones), 64'd1);
      chk("latency", 64'(seen), 64'(lat));
      chk("we pulses", 64'(pulses), 64'd16);
      chk("we width errors", 64'(e_w), 64'd0);
      chk("we gap errors", 64'(e_g), 64'd0);
      chk("lane order errors", 64'(e_l), 64'd0);
      chk("wbl data errors", 64'(e_d), 64'd0);
    end else chk("wr_done after abort", 64'(dones), 64'd0);
    chk("idle busy", 64'(ob_busy), 64'd0);
    chk("idle wl_en", 64'(ob_wl_en), 64'd0);
    chk("idle we", 64'(ob_we), 64'd0);
    chk("idle lane", 64'(ob_lane), 64'd0);
    chk("idle wbl", ob_wbl, 64'd0);
    chk("wl_addr hold", 64'(ob_wl_addr), rst_at < 0 ? 64'(a) : 64'd0);
    chk("err_ovf", 64'(ob_err), 64'(exp_err));
  endtask

  initial begin
    tl[0]  = '{0,  1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
    tl[1]  = '{1,  1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
    tl[2]  = '{2,  1'b1, 1'b1, 1'b0, 1'b1, 4'd0};
    tl[3]  = '{5,  1'b1, 1'b1, 1'b0, 1'b1, 4'd0};
    tl[4]  = '{6,  1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
    tl[5]  = '{7,  1'b1, 1'b1, 1'b0, 1'b1, 4'd1};
    tl[6]  = '{11, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1};
    tl[7]  = '{12, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2};
    tl[8]  = '{76, 1'b1, 1'b0, 1'b0, 1'b1, 4'd14};
    tl[9]  = '{77, 1'b1, 1'b1, 1'b0, 1'b1, 4'd15};
    tl[10] = '{80, 1'b1, 1'b1, 1'b0, 1'b1, 4'd15};
    tl[11] = '{81, 1'b1, 1'b0, 1'b0, 1'b1, 4'd15};
    tl[12] = '{83, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0};
    drive(1'b1, 6'h3F, 64'hFFFF);
    rst = 1'b1;
    tick;
    tick;
    chk_zero("reset");
    rst = 1'b0;
    drive(1'b0, 6'h00, 64'd0);
    tick;
    run(6'h2A, 64'd0, 4, 84, -1, -1, 1'b1, 1'b0);
    run(6'h15, 64'h5A5A5A5A5A5A5A5A, 4, 84, 9, -1, 1'b0, 1'b1);
    run(6'h07, 64'hF0F0F0F0F0F0F0F0, 4, 84, -1, 29, 1'b0, 1'b0);
    run(6'h3C, 64'h123456789ABCDEF0, 4, 84, -1, -1, 1'b0, 1'b0);
    run(6'h33, 64'hCAFEBABE00000000, 4, 84, 83, -1, 1'b0, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int r = 0; r < 64; r++) run(6'(r), {50'd0, 6'(r), 8'hA5}, 4, 84, -1, -1, 1'b0, 1'b0);
    sel = 1'b1;
    drive(1'b0, 6'h00, 64'd0);
    tick;
    run(6'h2A, 64'd0, 1, 34, -1, -1, 1'b0, 1'b0);
    run(6'h11, 64'h8000000000000001, 1, 34, -1, -1, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dram_wbl_write_ctrl.md
DRAM_WBL_WRITE_CTRL -- requirements
Module: dram_wbl_write_ctrl

Interface
REQ-001 Parameter T_SETUP, default 2: word-line setup cycles before the first lane write (legal range 1-15).
REQ-002 Parameter T_WE, default 4: write-enable pulse width per lane, in cycles (legal range 1-15).
REQ-003 Parameter T_REC, default 2: write-recovery cycles after the last lane (legal range 1-15).
REQ-004 CLK  in  1  the only clock; all logic on posedge.
REQ-005 RST  in  1  reset, synchronous and active-high.
REQ-006 IO_EN  in  1  write request; one-cycle pulse.
REQ-007 ADDR  in  6  row address, sampled with IO_EN.
REQ-008 WBL_DATA1..WBL_DATA16  in  64 each  lane data, sampled with IO_EN; WBL_DATAn maps to lane n-1.
REQ-009 wr_done  out  1  one-cycle pulse when the row write is complete.
REQ-010 BUSY  out  1  high from the cycle after IO_EN is accepted until the cycle after the wr_done pulse.
REQ-011 ERR_OVF  out  1  sticky flag; set when IO_EN arrives while BUSY.
REQ-012 WL_EN  out  1  word-line enable to the macro.
REQ-013 WL_ADDR  out  6  latched row address.
REQ-014 WE  out  1  lane write strobe.
REQ-015 LANE  out  4  active lane index.
REQ-016 WBL  out  64  write-bitline data for the current lane.

Function
REQ-017 States: IDLE, SETUP, WRITE, GAP, REC, DONE.
REQ-018 In IDLE, IO_EN=1 shall latch ADDR and all 16 words into internal registers and move to SETUP at the next edge.
REQ-019 SETUP lasts exactly T_SETUP cycles with WL_EN=1, WE=0, LANE=0, then goes to WRITE.
REQ-020 WRITE lasts exactly T_WE cycles with WL_EN=1, WE=1, LANE=k and WBL=latched word k.
REQ-021 After WRITE, for k<15: one GAP cycle (WE=0, WBL and LANE held), then LANE becomes k+1 and the block returns to WRITE.
REQ-022 After WRITE for k=15: REC for exactly T_REC cycles with WL_EN=1 and WE=0, then DONE.
REQ-023 DONE lasts one cycle with wr_done=1 and WL_EN=0, then IDLE.
REQ-024 Latency: wr_done shall be high exactly T_SETUP+16*T_WE+15+T_REC+1 cycles after the IO_EN sampling edge (84 with defaults).
REQ-025 In IDLE: WL_EN=0, WE=0, LANE=0, WBL=0; WL_ADDR holds its last latched value.
REQ-026 IO_EN in any state other than IDLE (including DONE) shall be ignored and shall set ERR_OVF; latched data and sequencing shall be unaffected.
REQ-027 IO_EN in the cycle after DONE (state IDLE) shall be accepted normally, giving back-to-back rows.
REQ-028 Timing counters shall be 4 bits wide and reload at each state entry; the lane counter shall not wrap past 15.
REQ-029 ERR_OVF shall clear only on RST.

Reset
REQ-030 RST=1 at a clock edge shall force IDLE and drive wr_done=0, BUSY=0, ERR_OVF=0, WL_EN=0, WL_ADDR=0, WE=0, LANE=0, WBL=0, and clear all latched data.
REQ-031 RST asserted mid-write shall abort the write immediately with no wr_done pulse; IO_EN sampled together with RST shall be discarded.

Structure
REQ-032 The state enumeration, NUM_LANES=16, and the default timing constants shall live in the shared DRAM package used by the key/S-box init path.
REQ-033 One sub-module, wbl_lane_mux, shall select the active 64-bit lane word from the 16 latched words by LANE; all sequencing stays in the top module.

Verification
REQ-034 Defaults; IO_EN with ADDR=6'h2A and WBL_DATAn=64'h0101..01*n -> WL_ADDR=2A; sixteen WE pulses, each 4 cycles wide with 1 gap cycle between them; LANE 0..15 with matching WBL; wr_done exactly 84 cycles after IO_EN.
REQ-035 Second IO_EN 10 cycles into a write -> ERR_OVF=1 and stays 1; first write completes unchanged; only one wr_done.
REQ-036 RST at cycle 30 of a write -> all outputs zero at the next cycle; no wr_done; next IO_EN runs a full 84-cycle write.
REQ-037 IO_EN on the cycle after wr_done, 64 times with ADDR 0..63 -> 64 wr_done pulses, each row written fully; ERR_OVF=0.
REQ-038 T_SETUP=1, T_WE=1, T_REC=1 -> wr_done 34 cycles after IO_EN; WE is high in 16 single cycles, each separated by one low cycle.
